// File: rtl/branch_predictor.sv
// Fetch-side BTB with 2-bit saturating direction counters and the EXE redirect code.
// Optional BP_STATS_EN adds saturating branch and mispredict counters as extra outputs.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 58
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_if,
    output logic        jump_if,
    output logic [63:0] pc_target_if,
    input  logic        stall,
    input  logic        flush_exe,
    input  logic        br_inst_exe,
    input  logic        br_taken_exe,
    input  logic [63:0] pc_exe,
    input  logic [63:0] target_exe,
    input  logic        pred_taken_exe,
    input  logic [63:0] pred_target_exe,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred,
`endif
    output logic [1:0]  exe_change
);

    typedef enum logic [1:0] {
        REDIR_SEQ    = 2'b00,
        REDIR_NONE   = 2'b01,
        REDIR_TARGET = 2'b10
    } redirect_t;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [63:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_if;
    logic [IDX_W-1:0] idx_exe;
    logic [TAG_W-1:0] tag_if;
    logic [TAG_W-1:0] tag_exe;
    logic             hit_if;
    logic             hit_exe;
    logic             upd;
    redirect_t        redirect;
    logic             unused_pc_bits;

    assign idx_if  = pc_if[IDX_W+1:2];
    assign idx_exe = pc_exe[IDX_W+1:2];
    assign tag_if  = pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign tag_exe = pc_exe[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{pc_if[1:0], pc_exe[1:0]};

    // Lookup reads the registered table only, so a same-cycle update is not visible here.
    assign hit_if       = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign jump_if      = hit_if && ctr_q[idx_if][1];
    assign pc_target_if = hit_if ? target_q[idx_if] : '0;

    assign hit_exe = valid_q[idx_exe] && (tag_q[idx_exe] == tag_exe);
    assign upd     = br_inst_exe && !stall && !flush_exe;

    always_comb begin
        redirect = REDIR_NONE;
        if (rst || flush_exe) begin
            redirect = REDIR_NONE;
        end else if (pred_taken_exe && (!br_inst_exe || !br_taken_exe)) begin
            redirect = REDIR_SEQ;
        end else if (br_inst_exe && br_taken_exe &&
                     (!pred_taken_exe || (pred_target_exe != target_exe))) begin
            redirect = REDIR_TARGET;
        end
    end

    assign exe_change = redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '{default: 1'b0};
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: 2'b01};
        end else if (upd) begin
            if (hit_exe) begin
                if (br_taken_exe) begin
                    ctr_q[idx_exe]    <= (ctr_q[idx_exe] == 2'b11) ? 2'b11 : ctr_q[idx_exe] + 2'd1;
                    target_q[idx_exe] <= target_exe;
                end else begin
                    ctr_q[idx_exe]    <= (ctr_q[idx_exe] == 2'b00) ? 2'b00 : ctr_q[idx_exe] - 2'd1;
                end
            end else if (br_taken_exe) begin
                // Allocation evicts whatever aliased entry occupied this index.
                valid_q[idx_exe]  <= 1'b1;
                tag_q[idx_exe]    <= tag_exe;
                target_q[idx_exe] <= target_exe;
                ctr_q[idx_exe]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (upd && (redirect != REDIR_NONE) && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected values are queued as stimulus is
// driven, then popped and compared against DUT outputs before the next clock edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_if;
    logic        jump_if;
    logic [63:0] pc_target_if;
    logic        stall;
    logic        flush_exe;
    logic        br_inst_exe;
    logic        br_taken_exe;
    logic [63:0] pc_exe;
    logic [63:0] target_exe;
    logic        pred_taken_exe;
    logic [63:0] pred_target_exe;
    logic [1:0]  exe_change;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    typedef struct {
        string       name;
        logic [63:0] value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .IDX_W(4), .TAG_W(58)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .jump_if         (jump_if),
        .pc_target_if    (pc_target_if),
        .stall           (stall),
        .flush_exe       (flush_exe),
        .br_inst_exe     (br_inst_exe),
        .br_taken_exe    (br_taken_exe),
        .pc_exe          (pc_exe),
        .target_exe      (target_exe),
        .pred_taken_exe  (pred_taken_exe),
        .pred_target_exe (pred_target_exe),
`ifdef BP_STATS_EN
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred),
`endif
        .exe_change      (exe_change)
    );

    task automatic push_exp(input string name, input logic [63:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.name, obs, e.value);
            end
        end
    endtask

    task automatic lookup(input string tag, input logic [63:0] pc,
                          input logic exp_jump, input logic [63:0] exp_target);
        pc_if = pc;
        push_exp({tag, "_jump_if"}, {63'd0, exp_jump});
        push_exp({tag, "_pc_target_if"}, exp_target);
        #1;
        check({63'd0, jump_if});
        check(pc_target_if);
    endtask

    task automatic resolve(input string tag, input logic [63:0] pc, input logic br,
                           input logic taken, input logic [63:0] tgt,
                           input logic ptaken, input logic [63:0] ptgt,
                           input logic st, input logic fl, input logic [1:0] exp_chg);
        pc_exe          = pc;
        br_inst_exe     = br;
        br_taken_exe    = taken;
        target_exe      = tgt;
        pred_taken_exe  = ptaken;
        pred_target_exe = ptgt;
        stall           = st;
        flush_exe       = fl;
        push_exp({tag, "_exe_change"}, {62'd0, exp_chg});
        #1;
        check({62'd0, exe_change});
        @(posedge clk);
        @(negedge clk);
        br_inst_exe    = 1'b0;
        br_taken_exe   = 1'b0;
        pred_taken_exe = 1'b0;
        stall          = 1'b0;
        flush_exe      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        pc_if           = 64'h1000;
        stall           = 1'b0;
        flush_exe       = 1'b0;
        br_inst_exe     = 1'b1;
        br_taken_exe    = 1'b1;
        pc_exe          = 64'h1000;
        target_exe      = 64'h2000;
        pred_taken_exe  = 1'b0;
        pred_target_exe = 64'h0;

        // Reset held across an edge with a would-be mispredict on the EXE inputs.
        @(posedge clk);
        @(negedge clk);
        push_exp("rst_exe_change", 64'd1);
        #1;
        check({62'd0, exe_change});
        lookup("rst", 64'h1000, 1'b0, 64'h0);
`ifdef BP_STATS_EN
        push_exp("rst_stat_branches", 64'd0);
        check({32'd0, stat_branches});
`endif
        @(negedge clk);
        rst         = 1'b0;
        br_inst_exe = 1'b0;

        lookup("cold", 64'h1000, 1'b0, 64'h0);

        resolve("alloc", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 1'b0, 2'b10);
        lookup("alloc", 64'h1000, 1'b1, 64'h2000);

        resolve("dec", 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h2000, 1'b0, 1'b0, 2'b00);
        lookup("dec", 64'h1000, 1'b0, 64'h2000);

        // ctr 01 -> 10 -> 11 -> 11 -> 11; only the first arrives unpredicted.
        resolve("inc0", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h2000, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++)
            resolve("incN", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b0, 1'b0, 2'b01);
        lookup("sat", 64'h1000, 1'b1, 64'h2000);

        resolve("sat_dec", 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h2000, 1'b0, 1'b0, 2'b00);
        lookup("sat_dec", 64'h1000, 1'b1, 64'h2000);

        resolve("retarget", 64'h1000, 1'b1, 1'b1, 64'h3000, 1'b1, 64'h2000, 1'b0, 1'b0, 2'b10);
        lookup("retarget", 64'h1000, 1'b1, 64'h3000);

        resolve("stall_tk", 64'h1000, 1'b1, 1'b1, 64'h4000, 1'b1, 64'h3000, 1'b1, 1'b0, 2'b10);
        resolve("stall_nt0", 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h3000, 1'b1, 1'b0, 2'b00);
        resolve("stall_nt1", 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h3000, 1'b1, 1'b0, 2'b00);
        lookup("stall", 64'h1000, 1'b1, 64'h3000);

        resolve("flush_tk", 64'h1000, 1'b1, 1'b1, 64'h4000, 1'b0, 64'h0, 1'b0, 1'b1, 2'b01);
        resolve("flush_nt", 64'h1000, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h3000, 1'b0, 1'b1, 2'b01);
        lookup("flush", 64'h1000, 1'b1, 64'h3000);

        resolve("nonbr", 64'h1000, 1'b0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b0, 1'b0, 2'b00);
        lookup("nonbr", 64'h1000, 1'b1, 64'h3000);

        resolve("alias", 64'h1040, 1'b1, 1'b1, 64'h5000, 1'b0, 64'h0, 1'b0, 1'b0, 2'b10);
        lookup("alias_old", 64'h1000, 1'b0, 64'h0);
        lookup("alias_new", 64'h1040, 1'b1, 64'h5000);

        resolve("miss_nt", 64'h2040, 1'b1, 1'b0, 64'h2044, 1'b0, 64'h0, 1'b0, 1'b0, 2'b01);
        lookup("miss_nt", 64'h1040, 1'b1, 64'h5000);
        lookup("miss_nt_other", 64'h2040, 1'b0, 64'h0);
        lookup("other_idx", 64'h1004, 1'b0, 64'h0);

`ifdef BP_STATS_EN
        push_exp("stat_branches", 64'd10);
        push_exp("stat_mispred", 64'd6);
        check({32'd0, stat_branches});
        check({32'd0, stat_mispred});
`endif

        // Mid-run reset: table cleared at once and redirect suppressed.
        br_inst_exe     = 1'b1;
        br_taken_exe    = 1'b1;
        pc_exe          = 64'h1040;
        target_exe      = 64'h6000;
        pred_taken_exe  = 1'b0;
        rst             = 1'b1;
        push_exp("midrst_exe_change", 64'd1);
        #1;
        check({62'd0, exe_change});
        lookup("midrst", 64'h1040, 1'b0, 64'h0);
        @(negedge clk);
        rst         = 1'b0;
        br_inst_exe = 1'b0;
        lookup("post_rst", 64'h1040, 1'b0, 64'h0);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
